// File: rtl/mprjram_arbiter.sv
// Round-robin arbiter sharing the single-port user-project BRAM between the Wishbone
// slave path and an accelerator master, with fixed read latency and byte-lane writes.
module mprjram_arbiter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned BRAM_LAT = 10
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              acc_req_i,
  input  logic              acc_we_i,
  input  logic [3:0]        acc_be_i,
  input  logic [ADDR_W-1:0] acc_addr_i,
  input  logic [31:0]       acc_wdata_i,
  output logic              acc_ack_o,
  output logic [31:0]       acc_rdata_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i,
  output logic [15:0]       conflict_cnt_o
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CONF_W = 16;
  localparam logic [7:0]  MPRJ_BASE = 8'h38;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

  state_e              state_q, state_d;
  logic                owner_acc_q, owner_acc_d;
  logic                last_acc_q, last_acc_d;
  logic                op_we_q, op_we_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CONF_W-1:0]   conflict_q, conflict_d;
  logic                ram_en_q, ram_en_d;
  logic [BE_W-1:0]     ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                wbs_ack_q, wbs_ack_d;
  logic [DATA_W-1:0]   wbs_dat_q, wbs_dat_d;
  logic                acc_ack_q, acc_ack_d;
  logic [DATA_W-1:0]   acc_rdata_q, acc_rdata_d;

  logic                wb_req_c;
  logic                wb_live_c;
  logic                contend_c;
  logic                acc_gnt_c;
  logic [ADDR_W-1:0]   wb_addr_c;
  logic                unused_adr_c;

  assign wb_live_c    = wbs_cyc_i & wbs_stb_i;
  assign wb_req_c     = wb_live_c & (wbs_adr_i[31:24] == MPRJ_BASE);
  assign wb_addr_c    = wbs_adr_i[ADDR_W+1:2];
  assign unused_adr_c = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};
  assign contend_c    = wb_req_c & acc_req_i;
  // On contention the requester that did not win last time gets the BRAM.
  assign acc_gnt_c    = acc_req_i & (~wb_req_c | ~last_acc_q);

  always_ff @(posedge clock) begin
    if (!resetb) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (wb_req_c | acc_req_i) state_d = ST_ISSUE;
      ST_ISSUE: state_d = op_we_q ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (cnt_q == '0) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered BRAM strobes, acks and captured read data.
  always_comb begin
    owner_acc_d = owner_acc_q;
    last_acc_d  = last_acc_q;
    op_we_d     = op_we_q;
    cnt_d       = cnt_q;
    conflict_d  = conflict_q;
    ram_en_d    = 1'b0;
    ram_we_d    = '0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    wbs_ack_d   = 1'b0;
    wbs_dat_d   = wbs_dat_q;
    acc_ack_d   = 1'b0;
    acc_rdata_d = acc_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wb_req_c | acc_req_i) begin
          owner_acc_d = acc_gnt_c;
          last_acc_d  = acc_gnt_c;
          ram_en_d    = 1'b1;
          if (contend_c && (conflict_q != '1)) conflict_d = conflict_q + CONF_W'(1);
          if (acc_gnt_c) begin
            op_we_d     = acc_we_i;
            ram_addr_d  = acc_addr_i;
            ram_wdata_d = acc_wdata_i;
            ram_we_d    = acc_we_i ? acc_be_i : '0;
          end else begin
            op_we_d     = wbs_we_i;
            ram_addr_d  = wb_addr_c;
            ram_wdata_d = wbs_dat_i;
            ram_we_d    = wbs_we_i ? wbs_sel_i : '0;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d = CNT_W'(BRAM_LAT - 1);
        if (op_we_q) begin
          if (owner_acc_q) acc_ack_d = 1'b1;
          else             wbs_ack_d = wb_live_c;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          if (owner_acc_q) begin
            acc_ack_d   = 1'b1;
            acc_rdata_d = ram_rdata_i;
          end else if (wb_live_c) begin
            wbs_ack_d = 1'b1;
            wbs_dat_d = ram_rdata_i;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      owner_acc_q <= 1'b0;
      last_acc_q  <= 1'b1;
      op_we_q     <= 1'b0;
      cnt_q       <= '0;
      conflict_q  <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      wbs_ack_q   <= 1'b0;
      wbs_dat_q   <= '0;
      acc_ack_q   <= 1'b0;
      acc_rdata_q <= '0;
    end else begin
      owner_acc_q <= owner_acc_d;
      last_acc_q  <= last_acc_d;
      op_we_q     <= op_we_d;
      cnt_q       <= cnt_d;
      conflict_q  <= conflict_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      wbs_ack_q   <= wbs_ack_d;
      wbs_dat_q   <= wbs_dat_d;
      acc_ack_q   <= acc_ack_d;
      acc_rdata_q <= acc_rdata_d;
    end
  end

  assign wbs_ack_o      = wbs_ack_q;
  assign wbs_dat_o      = wbs_dat_q;
  assign acc_ack_o      = acc_ack_q;
  assign acc_rdata_o    = acc_rdata_q;
  assign ram_en_o       = ram_en_q;
  assign ram_we_o       = ram_we_q;
  assign ram_addr_o     = ram_addr_q;
  assign ram_wdata_o    = ram_wdata_q;
  assign conflict_cnt_o = conflict_q;

endmodule

// File: tb/tb_mprjram_arbiter.sv
// Bench for mprjram_arbiter: BRAM stand-in, transaction-timestamp reference model checked
// every cycle, directed scenarios pinned with literals, then randomized two-master traffic.
module tb_mprjram_arbiter;

  localparam int LAT = 10;

  logic        clock = 1'b0;
  logic        resetb;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        acc_req_i, acc_we_i;
  logic [3:0]  acc_be_i;
  logic [9:0]  acc_addr_i;
  logic [31:0] acc_wdata_i;
  logic        acc_ack_o;
  logic [31:0] acc_rdata_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [9:0]  ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;
  logic [15:0] conflict_cnt_o;

  int cyc_n = 0;
  int pass_cnt = 0;
  int tot_cnt = 0;
  bit chk_en = 1'b0;

  mprjram_arbiter #(.ADDR_W(10), .BRAM_LAT(LAT)) dut (
    .clock(clock), .resetb(resetb),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .acc_req_i(acc_req_i), .acc_we_i(acc_we_i), .acc_be_i(acc_be_i), .acc_addr_i(acc_addr_i),
    .acc_wdata_i(acc_wdata_i), .acc_ack_o(acc_ack_o), .acc_rdata_o(acc_rdata_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .conflict_cnt_o(conflict_cnt_o)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc_n <= cyc_n + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc_n);
    $fatal(1);
  end

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return {16'(i), 16'(i * 7 + 3)} ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
  endtask

  task automatic fail_now(input string name);
    tot_cnt++;
    $display("FAIL %s: wait bound expired, got no event expected one (cycle %0d)", name, cyc_n);
  endtask

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  // which: 0 ram_en_o, 1 wbs_ack_o, 2 acc_ack_o; returns the cycle it was seen in
  task automatic wait_sig(input int which, input int bound, output int t);
    logic s;
    t = -1000;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      s = (which == 0) ? ram_en_o : (which == 1) ? wbs_ack_o : acc_ack_o;
      if (s) begin
        t = cyc_n;
        return;
      end
    end
    fail_now($sformatf("wait_sig%0d", which));
  endtask

  // BRAM stand-in: writes commit in the enable cycle, read data is valid only in cycle T+LAT
  logic [31:0] mem [1024];
  int          rd_issue;
  logic [9:0]  rd_addr;
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
    rd_issue = -1000;
    rd_addr = '0;
    ram_rdata_i = '0;
    forever begin
      @(negedge clock);
      if (ram_en_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_we_o[b]) mem[ram_addr_o][b*8 +: 8] = ram_wdata_o[b*8 +: 8];
        if (ram_we_o == 4'b0) begin
          rd_issue = cyc_n;
          rd_addr = ram_addr_o;
        end
      end
      @(posedge clock);
      #1;
      ram_rdata_i = (cyc_n == rd_issue + LAT) ? mem[rd_addr] : $urandom();
    end
  end

  // Reference model: each grant is a timestamped transaction (issue cycle, ack cycle).
  logic [31:0] model_mem [1024];
  initial begin
    int c, m_free, m_issue, m_ack;
    bit m_own_acc, m_we, m_alive, m_last_acc, g_acc, wbreq, e_wack, e_aack;
    logic [3:0]  m_be;
    logic [9:0]  m_addr, h_addr;
    logic [31:0] m_wd, h_wd, m_rd, h_wbdat, h_accdat;
    logic [15:0] m_conf;
    for (int i = 0; i < 1024; i++) model_mem[i] = init_word(i);
    m_free = 0; m_issue = -10; m_ack = -10; m_own_acc = 0; m_we = 0; m_alive = 0;
    m_last_acc = 1; m_be = '0; m_addr = '0; h_addr = '0; m_wd = '0; h_wd = '0; m_rd = '0;
    h_wbdat = '0; h_accdat = '0; m_conf = '0;
    forever begin
      @(negedge clock);
      c = cyc_n;
      e_wack = 0;
      e_aack = 0;
      if (c == m_issue) begin
        h_addr = m_addr;
        h_wd = m_wd;
      end
      if (c == m_ack) begin
        if (m_own_acc) begin
          e_aack = 1;
          if (!m_we) h_accdat = m_rd;
        end else if (m_alive) begin
          e_wack = 1;
          if (!m_we) h_wbdat = m_rd;
        end
      end
      if (chk_en) begin
        chk("ram_en", 32'(ram_en_o), 32'(c == m_issue));
        chk("ram_we", 32'(ram_we_o), 32'((c == m_issue && m_we) ? m_be : 4'b0));
        chk("ram_addr", 32'(ram_addr_o), 32'(h_addr));
        chk("ram_wdata", ram_wdata_o, h_wd);
        chk("wbs_ack", 32'(wbs_ack_o), 32'(e_wack));
        chk("wbs_dat", wbs_dat_o, h_wbdat);
        chk("acc_ack", 32'(acc_ack_o), 32'(e_aack));
        chk("acc_rdata", acc_rdata_o, h_accdat);
        chk("conflict_cnt", 32'(conflict_cnt_o), 32'(m_conf));
      end
      if (c == m_ack - 1) m_alive = wbs_cyc_i & wbs_stb_i;
      wbreq = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == 8'h38);
      if (resetb !== 1'b1) begin
        m_issue = -10; m_ack = -10; m_free = c + 1; m_alive = 0; m_last_acc = 1;
        m_conf = '0; h_addr = '0; h_wd = '0; h_wbdat = '0; h_accdat = '0;
      end else if (c >= m_free && (wbreq || acc_req_i)) begin
        if (wbreq && acc_req_i) begin
          g_acc = !m_last_acc;
          if (m_conf != 16'hFFFF) m_conf = m_conf + 16'd1;
        end else begin
          g_acc = acc_req_i;
        end
        m_last_acc = g_acc;
        m_own_acc = g_acc;
        m_we   = g_acc ? acc_we_i : wbs_we_i;
        m_be   = g_acc ? acc_be_i : wbs_sel_i;
        m_addr = g_acc ? acc_addr_i : wbs_adr_i[11:2];
        m_wd   = g_acc ? acc_wdata_i : wbs_dat_i;
        if (m_we) begin
          for (int b = 0; b < 4; b++)
            if (m_be[b]) model_mem[m_addr][b*8 +: 8] = m_wd[b*8 +: 8];
        end
        m_rd = model_mem[m_addr];
        m_issue = c + 1;
        m_ack = m_we ? c + 2 : c + LAT + 2;
        m_free = m_ack + 1;
      end
    end
  end

  task automatic wb_idle();
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
  endtask

  task automatic acc_idle();
    acc_req_i = 0; acc_we_i = 0; acc_be_i = '0; acc_addr_i = '0; acc_wdata_i = '0;
  endtask

  task automatic do_reset();
    next_cyc();
    wb_idle();
    acc_idle();
    resetb = 0;
    repeat (2) next_cyc();
    resetb = 1;
  endtask

  task automatic wb_master(input int ncyc);
    int end_c, kind, lim;
    bit acked;
    end_c = cyc_n + ncyc;
    while (cyc_n < end_c) begin
      kind = int'($urandom_range(0, 9));
      next_cyc();
      wbs_adr_i = {(kind == 0) ? 8'h30 : 8'h38, 12'd0, 10'($urandom_range(0, 31)), 2'b00};
      wbs_we_i  = 1'($urandom_range(0, 1));
      wbs_sel_i = 4'($urandom());
      wbs_dat_i = $urandom();
      wbs_cyc_i = 1;
      wbs_stb_i = 1;
      lim = (kind == 0) ? int'($urandom_range(3, 20)) : (kind == 1) ? int'($urandom_range(1, 6)) : 200;
      acked = 0;
      for (int i = 0; i < lim; i++) begin
        @(negedge clock);
        if (wbs_ack_o) begin
          acked = 1;
          break;
        end
        next_cyc();
      end
      if (acked) next_cyc();
      else if (kind >= 2) fail_now("wb_master_ack");
      wbs_cyc_i = 0;
      wbs_stb_i = 0;
      if (!acked) repeat (15) next_cyc();
      repeat ($urandom_range(0, 3)) next_cyc();
    end
  endtask

  task automatic acc_master(input int ncyc);
    int end_c, kind, lim;
    bit acked;
    end_c = cyc_n + ncyc;
    while (cyc_n < end_c) begin
      kind = int'($urandom_range(0, 9));
      next_cyc();
      acc_addr_i  = 10'($urandom_range(0, 31));
      acc_we_i    = 1'($urandom_range(0, 1));
      acc_be_i    = 4'($urandom());
      acc_wdata_i = $urandom();
      acc_req_i   = 1;
      lim = (kind == 0) ? 1 : 200;
      acked = 0;
      for (int i = 0; i < lim; i++) begin
        @(negedge clock);
        if (acc_ack_o) begin
          acked = 1;
          break;
        end
        next_cyc();
      end
      if (acked) next_cyc();
      else if (kind != 0) fail_now("acc_master_ack");
      acc_req_i = 0;
      if (!acked) repeat (15) next_cyc();
      repeat ($urandom_range(0, 3)) next_cyc();
    end
  endtask

  initial begin
    int t0, t1, t2, ta, n_en, n_ack;
    bit saw, got;
    resetb = 0;
    wb_idle();
    acc_idle();
    repeat (3) next_cyc();
    resetb = 1;
    chk_en = 1;
    @(negedge clock);
    chk("rst_ram_en", 32'(ram_en_o), 32'd0);
    chk("rst_wbs_ack", 32'(wbs_ack_o), 32'd0);
    chk("rst_wbs_dat", wbs_dat_o, 32'd0);
    chk("rst_conflict", 32'(conflict_cnt_o), 32'd0);

    // Read of word 4 through the WB path
    next_cyc();
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h3800_0010;
    wait_sig(0, 20, t0);
    chk("t1_addr", 32'(ram_addr_o), 32'd4);
    wait_sig(1, 40, t1);
    chk("t1_latency", 32'(t1 - t0), 32'd11);
    chk("t1_data", wbs_dat_o, 32'hDEADBEEF);
    next_cyc();
    wb_idle();

    // Simultaneous requests right after reset, WB re-requests while the accelerator waits
    do_reset();
    next_cyc();
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h3800_0040;
    acc_req_i = 1; acc_we_i = 1; acc_be_i = 4'hF; acc_addr_i = 10'd8; acc_wdata_i = 32'h1234_5678;
    wait_sig(0, 20, t0);
    chk("t2_first_addr", 32'(ram_addr_o), 32'd16);
    wait_sig(1, 40, t1);
    next_cyc();
    wbs_adr_i = 32'h3800_0044;
    wait_sig(0, 20, t0);
    chk("t2_second_addr", 32'(ram_addr_o), 32'd8);
    chk("t2_second_we", 32'(ram_we_o), 32'hF);
    wait_sig(2, 20, ta);
    next_cyc();
    acc_idle();
    wait_sig(0, 20, t0);
    chk("t2_third_addr", 32'(ram_addr_o), 32'd17);
    wait_sig(1, 40, t1);
    next_cyc();
    wb_idle();
    @(negedge clock);
    chk("t2_conflicts", 32'(conflict_cnt_o), 32'd2);

    // Single-byte write then readback
    next_cyc();
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'b0010; wbs_adr_i = 32'h3800_0000;
    wbs_dat_i = 32'h0000_AB00;
    wait_sig(0, 20, t0);
    chk("t3_ram_we", 32'(ram_we_o), 32'b0010);
    wait_sig(1, 20, t1);
    chk("t3_ack_latency", 32'(t1 - t0), 32'd1);
    next_cyc();
    wb_idle();
    next_cyc();
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h3800_0000;
    wait_sig(1, 40, t1);
    chk("t3_readback", wbs_dat_o, 32'hA5A5_AB03);
    next_cyc();
    wb_idle();

    // Non-hit WB read held 50 cycles beside an accelerator read
    next_cyc();
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0000;
    acc_req_i = 1; acc_we_i = 0; acc_be_i = 4'h0; acc_addr_i = 10'd8;
    n_en = 0; n_ack = 0; got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (ram_en_o) n_en++;
      if (wbs_ack_o) n_ack++;
      if (acc_ack_o) begin
        got = 1;
        chk("t4_acc_rdata", acc_rdata_o, 32'h1234_5678);
      end
      next_cyc();
      if (got) acc_req_i = 0;
    end
    wb_idle();
    acc_idle();
    chk("t4_acc_done", 32'(got), 32'd1);
    chk("t4_ram_en_count", 32'(n_en), 32'd1);
    chk("t4_wb_acks", 32'(n_ack), 32'd0);

    // WB read abandoned mid-flight while an accelerator read waits
    next_cyc();
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h3800_0050;
    wait_sig(0, 20, t0);
    next_cyc();
    acc_req_i = 1; acc_we_i = 0; acc_be_i = 4'h0; acc_addr_i = 10'd9;
    next_cyc();
    next_cyc();
    wb_idle();
    saw = 0; t2 = -1000; ta = -1000;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (wbs_ack_o) saw = 1;
      if (ram_en_o) t2 = cyc_n;
      if (acc_ack_o) begin
        ta = cyc_n;
        break;
      end
    end
    if (ta < 0) fail_now("t5_acc_ack");
    chk("t5_no_wb_ack", 32'(saw), 32'd0);
    chk("t5_acc_issue", 32'(t2 - t0), 32'd13);
    chk("t5_acc_latency", 32'(ta - t2), 32'd11);
    chk("t5_acc_rdata", acc_rdata_o, init_word(9));
    next_cyc();
    acc_idle();

    fork
      wb_master(3000);
      acc_master(3000);
    join

    // Reset during a read
    repeat (20) next_cyc();
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h3800_000C;
    wait_sig(0, 40, t0);
    repeat (5) next_cyc();
    resetb = 0;
    wb_idle();
    next_cyc();
    resetb = 1;
    @(negedge clock);
    chk("t6_ram_en", 32'(ram_en_o), 32'd0);
    chk("t6_conflict", 32'(conflict_cnt_o), 32'd0);
    chk("t6_wbs_dat", wbs_dat_o, 32'd0);
    n_ack = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (wbs_ack_o) n_ack++;
    end
    chk("t6_no_ack", 32'(n_ack), 32'd0);

    fork
      wb_master(1500);
      acc_master(1500);
    join
    repeat (20) next_cyc();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
